// File: rtl/dsram_arbiter.sv
// Two-requester (fetch / load-store) arbiter for one single-ported data SRAM; ARB_RR_EN selects round-robin grant.
// Latency: read response SRAM_LAT+2 cycles after the request is first seen idle, write response after 2.
// Backpressure: one transaction in flight; requesters hold req and see stallreq until their rvalid pulse.
module dsram_arbiter #(
   parameter int unsigned SRAM_LAT = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_rvalid,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic [3:0]  data_wen,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_rvalid,
   output logic [31:0] data_rdata,
   output logic        sram_en,
   output logic [3:0]  sram_wen,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   output logic        stallreq_inst,
   output logic        stallreq_data
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef enum logic [1:0] {GNT_NONE, GNT_INST, GNT_DATA} gnt_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  wen;
      logic [31:0] wdata;
   } sram_req_t;

   state_t    state_q, state_d;
   gnt_t      gnt_q, gnt_d;
   logic [2:0] cnt_q, cnt_d;
   sram_req_t req_q, req_d;
   logic      en_q, en_d;
   logic      inst_rvalid_q, inst_rvalid_d;
   logic      data_rvalid_q, data_rvalid_d;
   logic [31:0] inst_rdata_q, inst_rdata_d;
   logic [31:0] data_rdata_q, data_rdata_d;
   logic      pick_data;

`ifdef ARB_RR_EN
   // last_grant: 0 = data, 1 = inst; on a tie the other port wins
   logic last_grant_q, last_grant_d;
   assign pick_data = data_req & (~inst_req | last_grant_q);
`else
   assign pick_data = data_req;
`endif

   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      cnt_d         = cnt_q;
      req_d         = req_q;
      req_d.wen     = 4'h0;
      req_d.wdata   = 32'h0;
      en_d          = 1'b0;
      inst_rvalid_d = 1'b0;
      data_rvalid_d = 1'b0;
      inst_rdata_d  = inst_rdata_q;
      data_rdata_d  = data_rdata_q;
`ifdef ARB_RR_EN
      last_grant_d  = last_grant_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (inst_req || data_req) begin
               state_d = ISSUE;
               en_d    = 1'b1;
               if (pick_data) begin
                  gnt_d       = GNT_DATA;
                  req_d.addr  = data_addr;
                  req_d.wen   = data_wen;
                  req_d.wdata = data_wdata;
               end else begin
                  gnt_d      = GNT_INST;
                  req_d.addr = inst_addr;
               end
`ifdef ARB_RR_EN
               last_grant_d = ~pick_data;
`endif
            end
         end
         ISSUE: begin
            if (req_q.wen != 4'h0) begin
               state_d       = RESP;
               data_rvalid_d = (gnt_q == GNT_DATA);
               inst_rvalid_d = (gnt_q == GNT_INST);
            end else begin
               state_d = WAIT;
               cnt_d   = 3'(SRAM_LAT - 1);
            end
         end
         WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d = RESP;
               if (gnt_q == GNT_DATA) begin
                  data_rdata_d  = sram_rdata;
                  data_rvalid_d = 1'b1;
               end else begin
                  inst_rdata_d  = sram_rdata;
                  inst_rvalid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
            gnt_d   = GNT_NONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= IDLE;
         gnt_q         <= GNT_NONE;
         cnt_q         <= 3'd0;
         req_q         <= '0;
         en_q          <= 1'b0;
         inst_rvalid_q <= 1'b0;
         data_rvalid_q <= 1'b0;
         inst_rdata_q  <= 32'h0;
         data_rdata_q  <= 32'h0;
`ifdef ARB_RR_EN
         last_grant_q  <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         cnt_q         <= cnt_d;
         req_q         <= req_d;
         en_q          <= en_d;
         inst_rvalid_q <= inst_rvalid_d;
         data_rvalid_q <= data_rvalid_d;
         inst_rdata_q  <= inst_rdata_d;
         data_rdata_q  <= data_rdata_d;
`ifdef ARB_RR_EN
         last_grant_q  <= last_grant_d;
`endif
      end
   end

   assign sram_en       = en_q;
   assign sram_wen      = req_q.wen;
   assign sram_addr     = req_q.addr;
   assign sram_wdata    = req_q.wdata;
   assign inst_rvalid   = inst_rvalid_q;
   assign inst_rdata    = inst_rdata_q;
   assign data_rvalid   = data_rvalid_q;
   assign data_rdata    = data_rdata_q;
   assign stallreq_inst = inst_req & ~inst_rvalid_q;
   assign stallreq_data = data_req & ~data_rvalid_q;

endmodule
